// File: rtl/banked_scatter_crossbar.sv
// Batch scatter crossbar: accepts N_IN (row, col, data) lanes and writes them to BANK_COUNT banks, one write per bank per cycle.
// Optional macro BANKED_XBAR_RR_EN replaces fixed lowest-index priority with a rotating priority pointer.
module banked_scatter_crossbar #(
    parameter int N_IN       = 16,
    parameter int BANK_COUNT = 32,
    parameter int COORD_W    = 8,
    parameter int DATA_W     = 8,
    parameter int SKEW       = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN-1:0]               in_lane_valid,
    input  logic [N_IN*COORD_W-1:0]       in_row,
    input  logic [N_IN*COORD_W-1:0]       in_col,
    input  logic [N_IN*DATA_W-1:0]        in_data,
    output logic [BANK_COUNT-1:0]         wr_en,
    output logic [BANK_COUNT*COORD_W-1:0] wr_row,
    output logic [BANK_COUNT*COORD_W-1:0] wr_col,
    output logic [BANK_COUNT*DATA_W-1:0]  wr_data,
    output logic                          busy,
    output logic                          batch_done
);

    localparam int BANK_W = $clog2(BANK_COUNT);
    localparam int LANE_W = (N_IN > 1) ? $clog2(N_IN) : 1;

    typedef enum logic {IDLE, ROUTE} state_t;

    state_t                          state_q;
    logic [N_IN-1:0]                 pending_q;
    logic [N_IN-1:0]                 pending_d;
    logic [COORD_W-1:0]              row_q  [N_IN];
    logic [COORD_W-1:0]              col_q  [N_IN];
    logic [DATA_W-1:0]               data_q [N_IN];
    logic [BANK_COUNT-1:0]           wr_en_q;
    logic [BANK_COUNT*COORD_W-1:0]   wr_row_q;
    logic [BANK_COUNT*COORD_W-1:0]   wr_col_q;
    logic [BANK_COUNT*DATA_W-1:0]    wr_data_q;
    logic                            batch_done_q;

    logic [BANK_W-1:0]               lane_bank [N_IN];
    logic [N_IN-1:0]                 lane_grant;
    logic [BANK_COUNT-1:0]           bank_hit;
    logic [LANE_W-1:0]               sel_lane  [BANK_COUNT];
    logic [LANE_W-1:0]               rr_base;

`ifdef BANKED_XBAR_RR_EN
    logic [LANE_W-1:0]               ptr_q;
    assign rr_base = ptr_q;
`else
    assign rr_base = '0;
`endif

    // Truncating the full-width sum keeps the low bits, i.e. mod BANK_COUNT.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_bank_map
            assign lane_bank[gi] = BANK_W'(32'(row_q[gi]) * 32'(SKEW) + 32'(col_q[gi]));
        end
    endgenerate

    // Each bank scans lanes starting at rr_base and takes the first pending match.
    always_comb begin : grant_logic
        int idx;
        idx        = 0;
        lane_grant = '0;
        bank_hit   = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            sel_lane[b] = '0;
        end
        for (int b = 0; b < BANK_COUNT; b++) begin
            for (int k = 0; k < N_IN; k++) begin
                idx = (int'(rr_base) + k) % N_IN;
                if (!bank_hit[b] && pending_q[LANE_W'(idx)] &&
                    lane_bank[LANE_W'(idx)] == BANK_W'(b)) begin
                    bank_hit[b]               = 1'b1;
                    sel_lane[b]               = LANE_W'(idx);
                    lane_grant[LANE_W'(idx)]  = 1'b1;
                end
            end
        end
    end

    assign pending_d = pending_q & ~lane_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            wr_en_q      <= '0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            wr_data_q    <= '0;
            batch_done_q <= 1'b0;
            for (int l = 0; l < N_IN; l++) begin
                row_q[l]  <= '0;
                col_q[l]  <= '0;
                data_q[l] <= '0;
            end
`ifdef BANKED_XBAR_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            batch_done_q <= 1'b0;
            wr_en_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int l = 0; l < N_IN; l++) begin
                            row_q[l]  <= in_row[l*COORD_W +: COORD_W];
                            col_q[l]  <= in_col[l*COORD_W +: COORD_W];
                            data_q[l] <= in_data[l*DATA_W +: DATA_W];
                        end
                        pending_q <= in_lane_valid;
                        if (in_lane_valid != '0) begin
                            state_q <= ROUTE;
                        end else begin
                            batch_done_q <= 1'b1;
                        end
                    end
                end
                ROUTE: begin
                    for (int b = 0; b < BANK_COUNT; b++) begin
                        if (bank_hit[b]) begin
                            wr_en_q[b]                        <= 1'b1;
                            wr_row_q[b*COORD_W +: COORD_W]    <= row_q[sel_lane[b]];
                            wr_col_q[b*COORD_W +: COORD_W]    <= col_q[sel_lane[b]];
                            wr_data_q[b*DATA_W +: DATA_W]     <= data_q[sel_lane[b]];
                        end
                    end
                    pending_q <= pending_d;
                    if (pending_d == '0) begin
                        state_q      <= IDLE;
                        batch_done_q <= 1'b1;
                    end
`ifdef BANKED_XBAR_RR_EN
                    ptr_q <= (ptr_q == LANE_W'(N_IN - 1)) ? '0 : ptr_q + 1'b1;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == ROUTE);
    assign wr_en      = wr_en_q;
    assign wr_row     = wr_row_q;
    assign wr_col     = wr_col_q;
    assign wr_data    = wr_data_q;
    assign batch_done = batch_done_q;

endmodule

// File: doc/banked_scatter_crossbar.md
Name: banked_scatter_crossbar

Overview:
Parametrised successor to the product-to-accumulator crossbar.
- Accepts one batch of N_IN (row, column, data) lanes per valid/ready handshake and holds it in internal registers.
- Scatters the batch over several cycles to BANK_COUNT accumulator buffer banks, at most one write per bank per cycle.
- Asserts busy while routing and pulses batch_done on the last write.
- Sits between coordinate computation / multiplier array and the accumulator buffer banks.

Parameters:
N_IN, 16, number of input lanes per batch
BANK_COUNT, 32, number of buffer banks (power of two, >= 2)
COORD_W, 8, row/column coordinate width
DATA_W, 8, data width per lane
SKEW, 3, per-row bank rotation factor

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  batch offered
in_ready  output  1  block can accept a batch
in_lane_valid  input  N_IN  per-lane valid mask, sampled on accept
in_row  input  N_IN x COORD_W  lane row coordinates
in_col  input  N_IN x COORD_W  lane column coordinates
in_data  input  N_IN x DATA_W  lane data
wr_en  output  BANK_COUNT  per-bank write strobe
wr_row  output  BANK_COUNT x COORD_W  row for that bank's write
wr_col  output  BANK_COUNT x COORD_W  column for that bank's write
wr_data  output  BANK_COUNT x DATA_W  data for that bank's write
busy  output  1  batch in flight
batch_done  output  1  one-cycle pulse, batch fully written

Behaviour:
- Clock clk, reset asynchronous active-low on reset_n.
- Reset values: all outputs 0 except in_ready = 1. State IDLE, pending mask 0, batch registers 0.
- Bank mapping: bank(l) = (col + row*SKEW) mod BANK_COUNT. Product is computed at full width, then truncated to log2(BANK_COUNT) bits.
- States: IDLE and ROUTE. in_ready = (state == IDLE); busy = (state == ROUTE).
- Accept: in_valid && in_ready at a rising edge captures row/col/data for all lanes and sets pending = in_lane_valid.
  - Mask nonzero: next state ROUTE.
  - Mask zero: stay IDLE, pulse batch_done in the following cycle, no writes.
- ROUTE, each cycle:
  - For every bank, grant the lowest-index pending lane mapping to it. Fixed priority unless the optional feature is enabled.
  - At the edge, register wr_en/wr_row/wr_col/wr_data for each granted bank, and set wr_en = 0 for ungranted banks.
  - wr_row/wr_col/wr_data hold their previous value when wr_en = 0.
  - pending &= ~grant.
  - If the updated pending is 0: next state IDLE, and batch_done = 1 in the same cycle the last writes are visible.
- Latency: first writes visible one cycle after the accept edge. Routing cycles = max lanes sharing one bank, from 1 to N_IN.
- Next accept: earliest on the edge ending the batch_done cycle, where in_ready = 1.
- in_valid or input changes during ROUTE are ignored; inputs are sampled only on accept.
- Reset mid-ROUTE discards the batch: outputs go to reset values, and no batch_done is issued.
- Lane order within one bank is strictly by grant priority. No lane is written twice and no valid lane is dropped.

Optional Feature:
BANKED_XBAR_RR_EN
- Defined: a log2(N_IN)-bit priority pointer (reset 0) makes each bank grant the first pending lane at index >= ptr, wrapping around. ptr advances by 1 each ROUTE cycle and holds in IDLE.
- Undefined: fixed lowest-index priority; identical functional write set, order differs only among lanes sharing a bank.

Test Plan:
- Conflict-free: N_IN=16, BANK_COUNT=32, mask 0xFFFF, row=0, col=i, data=i+1 -> one cycle later wr_en[15:0] = 1 with wr_data[i] = i+1; batch_done in the same cycle; in_ready next cycle.
- Full conflict: all lanes row=0, col=5 -> 16 consecutive cycles with only wr_en[5] = 1, data lanes in order 0..15; busy for 16 cycles; batch_done on the 16th.
- Skew and wrap: lane0 row=1 col=0 -> bank 3; lane1 row=11 col=0 -> bank 1 (33 mod 32); lane2 row=0 col=3 -> bank 3 conflicts with lane0 -> two cycles: {bank3 = lane0, bank1 = lane1}, then {bank3 = lane2}.
- Empty mask 0x0000 accepted -> no wr_en, batch_done one cycle after accept, busy never asserted.
- Reset asserted in the 3rd cycle of the full-conflict batch -> immediate all-zero outputs, in_ready = 1, no batch_done; a new batch after release routes correctly.
- With BANKED_XBAR_RR_EN, full-conflict batch -> bank 5 receives lanes 0,1,2,...,15, with ptr advancing each cycle. Second identical batch starts from the retained ptr; check the order matches ptr-first wrap.
